// File: rtl/control_unit.sv
// Multicycle MIPS-style main control FSM (Moore); outputs decode from the state register only.
// Latency: outputs follow the state register combinationally; instructions take 3 to 5 cycles FETCH to FETCH.
// Backpressure: none; the FSM advances every clock edge and never stalls.
module control_unit (
    input  logic       Clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    output logic       PCWriteCond,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [7:0] ControlState
);

    typedef enum logic [7:0] {
        ST_RESET     = 8'h00,
        ST_FETCH     = 8'h01,
        ST_DECODE    = 8'h02,
        ST_MEMADDR   = 8'h03,
        ST_MEMREAD   = 8'h04,
        ST_MEMWB     = 8'h05,
        ST_MEMWRITE  = 8'h06,
        ST_EXECUTE   = 8'h07,
        ST_RCOMPLETE = 8'h08,
        ST_BRANCH    = 8'h09,
        ST_JUMP      = 8'h0A,
        ST_ADDIEXEC  = 8'h0B,
        ST_ADDIWB    = 8'h0C,
        ST_ILLEGAL   = 8'hFF
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] opcode_q;

    // State register; reset forces RESET immediately, independent of the clock.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Opcode is captured once in DECODE so later instruction-register changes cannot redirect MEMADDR.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            opcode_q <= 6'h00;
        end else if (state == ST_DECODE) begin
            opcode_q <= Opcode;
        end
    end

    // Next-state selection; any encoding outside the enumerated set recovers to FETCH.
    always_comb begin
        state_nxt = ST_FETCH;
        case (state)
            ST_RESET:     state_nxt = ST_FETCH;
            ST_FETCH:     state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (Opcode)
                    OP_RTYPE:      state_nxt = ST_EXECUTE;
                    OP_LW, OP_SW:  state_nxt = ST_MEMADDR;
                    OP_BEQ:        state_nxt = ST_BRANCH;
                    OP_J:          state_nxt = ST_JUMP;
                    OP_ADDI:       state_nxt = ST_ADDIEXEC;
                    default:       state_nxt = ST_ILLEGAL;
                endcase
            end
            // Only lw and sw reach MEMADDR, so anything other than lw is treated as sw.
            ST_MEMADDR:   state_nxt = (opcode_q == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD:   state_nxt = ST_MEMWB;
            ST_EXECUTE:   state_nxt = ST_RCOMPLETE;
            ST_ADDIEXEC:  state_nxt = ST_ADDIWB;
            default:      state_nxt = ST_FETCH;
        endcase
    end

    // Moore output decode; every control defaults low so RESET, ILLEGAL and stray encodings are quiet.
    always_comb begin
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        case (state)
            ST_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            ST_DECODE: begin
                ALUSrcB = 2'b11;
            end
            ST_MEMADDR, ST_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ST_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ST_RCOMPLETE: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                PCWriteCond = 1'b1;
                ALUOp       = 2'b01;
                PCSource    = 2'b01;
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            ST_ADDIWB: begin
                RegWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign ControlState = state;

endmodule

// File: tb/tb_control_unit.sv
// Randomized instruction stream against a path/latency reference model for control_unit.
// Latency: one instruction per FETCH; each state is checked #1 after the rising edge.
// Backpressure: none; the bench tracks the FSM cycle by cycle with bounded loops.
module tb_control_unit;

    logic       Clk;
    logic       reset;
    logic [5:0] Opcode;
    logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst;
    logic [7:0] ControlState;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

    ctrl_t ctrl_obs;

    control_unit dut (
        .Clk          (Clk),
        .reset        (reset),
        .Opcode       (Opcode),
        .PCWriteCond  (PCWriteCond),
        .PCWrite      (PCWrite),
        .IorD         (IorD),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemtoReg     (MemtoReg),
        .IRWrite      (IRWrite),
        .PCSource     (PCSource),
        .ALUOp        (ALUOp),
        .ALUSrcB      (ALUSrcB),
        .ALUSrcA      (ALUSrcA),
        .RegWrite     (RegWrite),
        .RegDst       (RegDst),
        .ControlState (ControlState)
    );

    assign ctrl_obs = '{PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                        PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Control word the datapath should see in each state, written from the per-state output list.
    function automatic ctrl_t exp_ctrl(input logic [7:0] st);
        ctrl_t c;
        c = '0;
        if (st == 8'h01) begin c.mem_read = 1; c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'b01; end
        if (st == 8'h02) c.alu_src_b = 2'b11;
        if (st == 8'h03 || st == 8'h0B) begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
        if (st == 8'h04) begin c.mem_read = 1; c.i_or_d = 1; end
        if (st == 8'h05) begin c.reg_write = 1; c.mem_to_reg = 1; end
        if (st == 8'h06) begin c.mem_write = 1; c.i_or_d = 1; end
        if (st == 8'h07) begin c.alu_src_a = 1; c.alu_op = 2'b10; end
        if (st == 8'h08) begin c.reg_write = 1; c.reg_dst = 1; end
        if (st == 8'h09) begin c.alu_src_a = 1; c.pc_write_cond = 1; c.alu_op = 2'b01; c.pc_source = 2'b01; end
        if (st == 8'h0A) begin c.pc_write = 1; c.pc_source = 2'b10; end
        if (st == 8'h0C) c.reg_write = 1;
        return c;
    endfunction

    // Expected state walk for one instruction, starting at FETCH.
    function automatic void build_path(input logic [5:0] op, output logic [7:0] path [$]);
        path = {8'h01, 8'h02};
        if (op == 6'h00)      path = {path, 8'h07, 8'h08};
        else if (op == 6'h23) path = {path, 8'h03, 8'h04, 8'h05};
        else if (op == 6'h2B) path = {path, 8'h03, 8'h06};
        else if (op == 6'h04) path = {path, 8'h09};
        else if (op == 6'h02) path = {path, 8'h0A};
        else if (op == 6'h08) path = {path, 8'h0B, 8'h0C};
        else                  path = {path, 8'hFF};
    endfunction

    // Cycle count FETCH-to-FETCH by instruction class.
    function automatic int latency(input logic [5:0] op);
        if (op == 6'h23) return 5;
        if (op == 6'h2B || op == 6'h00 || op == 6'h08) return 4;
        return 3;
    endfunction

    function automatic logic [5:0] pick_opcode();
        logic [5:0] legal [6];
        logic [5:0] r;
        legal = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        if ($urandom_range(0, 6) != 6) return legal[$urandom_range(0, 5)];
        do r = 6'($urandom); while (r inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08});
        return r;
    endfunction

    // Walks one instruction from FETCH; Opcode is only meaningful in DECODE and scrambled elsewhere.
    // When late_op_valid is set, the scramble after DECODE is replaced by late_op.
    task automatic run_instr(input logic [5:0] op, input bit late_op_valid, input logic [5:0] late_op);
        logic [7:0] path [$];
        logic [7:0] exp_st;
        int cyc;
        build_path(op, path);
        cyc = 0;
        do begin
            exp_st = (cyc < path.size()) ? path[cyc] : 8'hEE;
            check($sformatf("state op=%0h cyc=%0d", op, cyc), 32'(ControlState), 32'(exp_st));
            check($sformatf("ctrl st=%0h", exp_st), 32'(ctrl_obs), 32'(exp_ctrl(exp_st)));
            check("mem_rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
            check("pcw_excl", 32'(PCWrite & PCWriteCond), 32'd0);
            if (ControlState == 8'h02) Opcode = op;
            else if (late_op_valid)    Opcode = late_op;
            else                       Opcode = 6'($urandom);
            tick();
            cyc++;
        end while (ControlState != 8'h01 && cyc < 16);
        check($sformatf("latency op=%0h", op), 32'(cyc), 32'(latency(op)));
    endtask

    initial begin
        reset  = 1'b1;
        Opcode = 6'h00;
        #2;
        check("reset_state_async", 32'(ControlState), 32'h00);
        tick();
        tick();
        check("reset_state", 32'(ControlState), 32'h00);
        check("reset_ctrl", 32'(ctrl_obs), 32'd0);
        reset = 1'b0;
        check("reset_hold_no_edge", 32'(ControlState), 32'h00);
        tick();
        check("first_edge_fetch", 32'(ControlState), 32'h01);

        // Directed sequence: lw, sw, R-type, beq, j, illegal, addi.
        run_instr(6'h23, 1'b0, 6'h00);
        run_instr(6'h2B, 1'b0, 6'h00);
        run_instr(6'h00, 1'b0, 6'h00);
        run_instr(6'h04, 1'b0, 6'h00);
        run_instr(6'h02, 1'b0, 6'h00);
        run_instr(6'h3F, 1'b0, 6'h00);
        run_instr(6'h08, 1'b0, 6'h00);

        // Opcode swaps to sw after DECODE; the latched lw must still steer to MEMREAD.
        run_instr(6'h23, 1'b1, 6'h2B);
        // And the reverse: latched sw must reach MEMWRITE even if lw appears later.
        run_instr(6'h2B, 1'b1, 6'h23);

        for (int i = 0; i < 200; i++) begin
            run_instr(pick_opcode(), 1'b0, 6'h00);
        end

        // Asynchronous reset in MEMWRITE must drop MemWrite before any clock edge.
        Opcode = 6'h2B;
        tick();
        tick();
        tick();
        check("pre_reset_state", 32'(ControlState), 32'h06);
        check("pre_reset_memwrite", 32'(MemWrite), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_state", 32'(ControlState), 32'h00);
        check("async_reset_memwrite", 32'(MemWrite), 32'd0);
        check("async_reset_ctrl", 32'(ctrl_obs), 32'd0);
        #2;
        reset = 1'b0;
        tick();
        check("resume_fetch", 32'(ControlState), 32'h01);

        // Reset between edges in EXECUTE, then the latched opcode restart behaviour via a fresh lw.
        Opcode = 6'h00;
        tick();
        tick();
        check("pre_reset_exec", 32'(ControlState), 32'h07);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_exec", 32'(ControlState), 32'h00);
        #1;
        reset = 1'b0;
        tick();
        run_instr(6'h23, 1'b0, 6'h00);
        run_instr(pick_opcode(), 1'b0, 6'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: Clk is the single clock, and reset is asynchronous and active-high.
REQ-002 The block SHALL have no parameters; all widths are fixed.
REQ-003 Clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces state RESET.
REQ-005 Opcode  input  6  instruction[31:26] from the instruction register; sampled only in DECODE.
REQ-006 PCWriteCond  output  1  PC write if ALU zero (branch).
REQ-007 PCWrite  output  1  unconditional PC write.
REQ-008 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 MemRead  output  1  memory read enable.
REQ-010 MemWrite  output  1  memory write enable.
REQ-011 MemtoReg  output  1  register write-data select: 0 = ALUOut, 1 = MDR.
REQ-012 IRWrite  output  1  instruction register load.
REQ-013 PCSource  output  2  next-PC mux: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-014 ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded.
REQ-015 ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
REQ-016 ALUSrcA  output  1  0 = PC, 1 = A.
REQ-017 RegWrite  output  1  register file write enable.
REQ-018 RegDst  output  1  destination select: 0 = rt, 1 = rd.
REQ-019 ControlState  output  8  current state encoding, for debug and benches.

Function
REQ-020 The block SHALL be a Moore FSM: every output is decoded from the state register only and never depends combinationally on Opcode.
REQ-021 The state encoding SHALL be: RESET=00h, FETCH=01h, DECODE=02h, MEMADDR=03h, MEMREAD=04h, MEMWB=05h, MEMWRITE=06h, EXECUTE=07h, RCOMPLETE=08h, BRANCH=09h, JUMP=0Ah, ADDIEXEC=0Bh, ADDIWB=0Ch, ILLEGAL=FFh.
REQ-022 Transitions: RESET->FETCH; FETCH->DECODE; MEMREAD->MEMWB; EXECUTE->RCOMPLETE; ADDIEXEC->ADDIWB; MEMWB, MEMWRITE, RCOMPLETE, BRANCH, JUMP, ADDIWB and ILLEGAL->FETCH.
REQ-023 DECODE SHALL go on Opcode as follows: 00h->EXECUTE; 23h or 2Bh->MEMADDR; 04h->BRANCH; 02h->JUMP; 08h->ADDIEXEC; any other value->ILLEGAL.
REQ-024 MEMADDR SHALL go to MEMREAD if the Opcode latched at DECODE is 23h, and to MEMWRITE if it is 2Bh; the latched opcode is an internal 6-bit register loaded only in DECODE.
REQ-025 Outputs per state (every signal not listed is 0):
  - FETCH: MemRead, IRWrite, PCWrite = 1; ALUSrcB = 01.
  - DECODE: ALUSrcB = 11.
  - MEMADDR: ALUSrcA = 1; ALUSrcB = 10.
  - MEMREAD: MemRead, IorD = 1.
  - MEMWB: RegWrite, MemtoReg = 1.
  - MEMWRITE: MemWrite, IorD = 1.
  - EXECUTE: ALUSrcA = 1; ALUOp = 10.
  - RCOMPLETE: RegWrite, RegDst = 1.
  - BRANCH: ALUSrcA, PCWriteCond = 1; ALUOp = 01; PCSource = 01.
  - JUMP: PCWrite = 1; PCSource = 10.
  - ADDIEXEC: ALUSrcA = 1; ALUSrcB = 10.
  - ADDIWB: RegWrite = 1.
  - RESET and ILLEGAL: all 0.
REQ-026 Instruction latency in cycles, counted from FETCH entry to the next FETCH entry, SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 3.
REQ-027 MemRead and MemWrite SHALL never be 1 in the same cycle, and PCWrite and PCWriteCond SHALL never be 1 in the same cycle.
REQ-028 Unreachable state encodings SHALL transition to FETCH on the next edge, with all outputs 0 while in such a state.
REQ-029 ControlState SHALL equal the state register at all times.

Reset
REQ-030 While reset is 1, the state SHALL be RESET (ControlState = 00h), all control outputs SHALL be 0, and the latched opcode SHALL be 00h; this takes effect immediately and asynchronously.
REQ-031 The first rising Clk edge after reset deasserts SHALL move the state to FETCH.
REQ-032 Reset asserted mid-instruction (for example in MEMWRITE) SHALL drop MemWrite to 0 without waiting for a clock edge.

Verification
REQ-033 Release reset, Opcode=23h -> ControlState sequence 00,01,02,03,04,05,01; RegWrite=1 and MemtoReg=1 only in state 05.
REQ-034 Opcode=2Bh -> sequence 01,02,03,06,01; MemWrite=1 and IorD=1 only in state 06; RegWrite stays 0 throughout.
REQ-035 Opcode=00h then 04h then 02h -> R-type takes 4 cycles with RegDst=1 in state 08; beq shows PCWriteCond=1, PCSource=01 in state 09; j shows PCWrite=1, PCSource=10 in state 0A.
REQ-036 Opcode=3Fh at DECODE -> ControlState FFh for one cycle with all outputs 0, then 01h.
REQ-037 Opcode changed from 23h to 2Bh during MEMADDR -> the FSM still takes MEMREAD (04h), proving the opcode was latched at DECODE.
REQ-038 reset pulsed asynchronously in state 06 -> MemWrite=0 and ControlState=00h before the next Clk edge; the FSM resumes at 01h after release.
